// File: rtl/lcd_cmd_issuer_if.sv
// Signal bundle between the command issuer and its environment.
// The push side comes from the host. The cmd/busy/done side connects to LCD_CTRL.
// slave  : the issuer itself.
// master : the host and LCD_CTRL taken together.
interface lcd_cmd_issuer_if;
    logic       push_valid;
    logic [3:0] push_cmd;
    logic       push_ready;
    logic       busy;
    logic       done;
    logic [3:0] cmd;
    logic       cmd_valid;

    modport master (
        output push_valid, push_cmd, busy, done,
        input  push_ready, cmd, cmd_valid
    );

    modport slave (
        input  push_valid, push_cmd, busy, done,
        output push_ready, cmd, cmd_valid
    );
endinterface

// File: rtl/lcd_cmd_issuer.sv
// Host-side command issuer for LCD_CTRL.
// Commands are queued in a FIFO and issued one at a time, only while busy is low.
// The block halts after the write command completes (done seen) or after a wait overrun.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | waiting for a queued command and busy low (never times out)
//   S_ISSUE    | cmd_valid high for this single cycle
//   S_GUARD    | busy ignored for one cycle, covering LCD_CTRL busy-rise latency
//   S_WAIT     | waiting for busy low after a non-write command
//   S_WAITDONE | waiting for done after the write command
//   S_HALT     | terminal until reset; pushes still accepted, nothing issued
module lcd_cmd_issuer #(
    parameter int         DEPTH     = 16,
    parameter logic [3:0] CMD_WRITE = 4'd0,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd_cmd_issuer_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             issued_cnt,
    output logic                   seq_done,
    output logic                   timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_WAITDONE,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   wait_cnt;
    logic            push_fire;
    logic            issue_fire;
    logic            done_fire;
    logic            to_fire;
    logic            wait_clr;
    logic            wait_inc;
    logic            wait_limit;

    assign bus.push_ready = (count < (AW+1)'(DEPTH));
    assign fifo_count     = count;
    assign push_fire      = bus.push_valid && bus.push_ready;
    assign wait_limit     = (wait_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. When an exit condition and the wait limit coincide, the exit wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (count != '0 && !bus.busy) state_nxt = S_ISSUE;
            S_ISSUE:    state_nxt = (bus.cmd == CMD_WRITE) ? S_WAITDONE : S_GUARD;
            S_GUARD:    state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.busy)      state_nxt = S_IDLE;
                else if (wait_limit) state_nxt = S_HALT;
            end
            S_WAITDONE: if (bus.done || wait_limit) state_nxt = S_HALT;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Per-state strobes that drive the datapath registers below.
    always_comb begin
        issue_fire = (state == S_IDLE) && (state_nxt == S_ISSUE);
        done_fire  = (state == S_WAITDONE) && bus.done;
        to_fire    = wait_limit &&
                     (((state == S_WAIT) && bus.busy) ||
                      ((state == S_WAITDONE) && !bus.done));
        wait_clr   = (state == S_ISSUE);
        wait_inc   = (state == S_GUARD) || (state == S_WAIT) || (state == S_WAITDONE);
    end

    // FIFO storage. It is not reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= bus.push_cmd;
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire)  wr_ptr <= wr_ptr + 1'b1;
            if (issue_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, issue_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Command output. cmd holds its last value between issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cmd       <= '0;
            bus.cmd_valid <= 1'b0;
        end else begin
            bus.cmd_valid <= issue_fire;
            if (issue_fire) bus.cmd <= mem[rd_ptr];
        end
    end

    // Wait counter, saturating issue counter and sticky status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            issued_cnt <= '0;
            seq_done   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (wait_clr)      wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
            if (wait_clr && issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 1'b1;
            if (done_fire) seq_done <= 1'b1;
            if (to_fire)   timeout  <= 1'b1;
        end
    end

endmodule
